// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for the shared single-port program/data memory.
// Master 0 (control unit) has fixed priority; a streak counter grants
// master 1 after MAX_STREAK consecutive master-0 wins while it waits.
// Every output is decoded from flops only, so no input reaches an output
// within the same cycle.
module mem_port_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 16,
  parameter int READ_LAT   = 2,   // 1..7
  parameter int MAX_STREAK = 4    // 0..15, 0 disables the starvation guard
) (
  input  logic              clk,
  input  logic              rst,       // async, active low
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_e;

  localparam logic [2:0] LAT_LAST   = 3'(READ_LAT - 1);
  localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);
  localparam bit         GUARD_EN   = (MAX_STREAK != 0);

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [2:0]          lat_q, lat_d;
  logic [3:0]          streak_q, streak_d;
  logic                grant1;

  // Next-state: arbitration and latching in IDLE, latency count in ACCESS.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    lat_d    = lat_q;
    streak_d = streak_q;
    grant1   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          // Master 1 wins alone, or when the guard says master 0 has had enough.
          grant1  = m1_req && (!m0_req || (GUARD_EN && streak_q == STREAK_MAX));
          owner_d = grant1;
          we_d    = grant1 ? m1_we    : m0_we;
          addr_d  = grant1 ? m1_addr  : m0_addr;
          wdata_d = grant1 ? m1_wdata : m0_wdata;
          lat_d   = 3'd0;
          state_d = ACCESS;
          // Streak only grows while master 1 is actually being passed over.
          if (!grant1 && m1_req)
            streak_d = (streak_q == 4'hF) ? streak_q : streak_q + 4'd1;
          else
            streak_d = 4'd0;
        end
      end
      ACCESS: begin
        if (we_q || lat_q == LAT_LAST) begin
          // Writes return zero data; reads take the memory word on this edge.
          rdata_d = we_q ? '0 : mem_rdata;
          state_d = ACK;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latched-request registers; reset aborts any transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      lat_q    <= 3'd0;
      streak_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      lat_q    <= lat_d;
      streak_q <= streak_d;
    end
  end

  // Output decode from registered state; rdata is gated so it is zero off-ack.
  always_comb begin
    mem_en    = (state_q == ACCESS);
    mem_we    = (state_q == ACCESS) && we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    busy      = (state_q != IDLE);
    owner     = owner_q;
    m0_ack    = (state_q == ACK) && !owner_q;
    m1_ack    = (state_q == ACK) &&  owner_q;
    m0_rdata  = m0_ack ? rdata_q : '0;
    m1_rdata  = m1_ack ? rdata_q : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a READ_LAT=2 memory model, a
// MAX_STREAK=4 instance for the main sequence and a MAX_STREAK=0 instance
// for the strict-priority case.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  // Main instance signals
  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [9:0]  m0_addr = 0, m1_addr = 0;
  logic [15:0] m0_wdata = 0, m1_wdata = 0;
  logic        m0_ack, m1_ack, mem_en, mem_we, busy, owner;
  logic [15:0] m0_rdata, m1_rdata, mem_wdata, mem_rdata;
  logic [9:0]  mem_addr;

  // Strict-priority instance signals
  logic        u1_m0_req = 0, u1_m1_req = 0;
  logic        u1_we = 0;
  logic [9:0]  u1_addr = 0;
  logic [15:0] u1_wdata = 0, u1_mem_rdata = 0;
  logic        u1_m0_ack, u1_m1_ack, u1_mem_en, u1_mem_we, u1_busy, u1_owner;
  logic [15:0] u1_m0_rdata, u1_m1_rdata, u1_mem_wdata;
  logic [9:0]  u1_mem_addr;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.ADDR_W(10), .DATA_W(16), .READ_LAT(2), .MAX_STREAK(4)) u0 (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner));

  mem_port_arbiter #(.ADDR_W(10), .DATA_W(16), .READ_LAT(2), .MAX_STREAK(0)) u1 (
    .clk(clk), .rst(rst),
    .m0_req(u1_m0_req), .m0_we(u1_we), .m0_addr(u1_addr), .m0_wdata(u1_wdata),
    .m0_ack(u1_m0_ack), .m0_rdata(u1_m0_rdata),
    .m1_req(u1_m1_req), .m1_we(u1_we), .m1_addr(u1_addr), .m1_wdata(u1_wdata),
    .m1_ack(u1_m1_ack), .m1_rdata(u1_m1_rdata),
    .mem_en(u1_mem_en), .mem_we(u1_mem_we), .mem_addr(u1_mem_addr),
    .mem_wdata(u1_mem_wdata), .mem_rdata(u1_mem_rdata),
    .busy(u1_busy), .owner(u1_owner));

  // Memory model: read data appears READ_LAT edges after mem_en rises;
  // outside a read it shows a junk word so early capture is visible.
  logic [15:0] mem [0:1023];
  logic [15:0] rd_q = 16'hDEAD;
  assign mem_rdata = rd_q;
  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    rd_q <= (mem_en && !mem_we) ? mem[mem_addr] : 16'hDEAD;
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    mem[10'h005] = 16'hBEEF;
    mem[10'h010] = 16'hA010;
    mem[10'h020] = 16'hB020;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Watch the main instance until an ack (bounded); returns at the ack negedge.
  task automatic wait_ack(output int who, output logic [15:0] rd, output int lat,
                          output int en_n, output int we_n, output logic [9:0] a,
                          output logic [15:0] wd, output bit stable);
    who = -1; rd = 0; lat = 0; en_n = 0; we_n = 0; a = 0; wd = 0; stable = 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      lat++;
      if (mem_en) begin
        if (en_n != 0 && (mem_addr != a || mem_wdata != wd)) stable = 0;
        en_n++;
        if (mem_we) we_n++;
        a  = mem_addr;
        wd = mem_wdata;
      end
      if (m0_ack || m1_ack) begin
        chk("ack_excl", 32'(m0_ack & m1_ack), 32'd0);
        who = m1_ack ? 1 : 0;
        rd  = m1_ack ? m1_rdata : m0_rdata;
        break;
      end
    end
  endtask

  initial begin
    int who, lat, en_n, we_n, n0, n1, hits;
    logic [15:0] rd, wd;
    logic [9:0]  a;
    bit          stable;
    int          exp_order [6];
    exp_order = '{0, 0, 0, 0, 1, 0};

    // Reset state
    #1 rst = 1'b0;
    #1;
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_owner", 32'(owner), 0);
    chk("rst_acks", 32'({m0_ack, m1_ack}), 0);
    chk("rst_rdata", 32'({m0_rdata, m1_rdata}), 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // 1: m0 read 0x005
    m0_req = 1; m0_we = 0; m0_addr = 10'h005;
    wait_ack(who, rd, lat, en_n, we_n, a, wd, stable);
    chk("t1_who", 32'(who), 0);
    chk("t1_rdata", 32'(rd), 32'hBEEF);
    chk("t1_lat", 32'(lat), 4);
    chk("t1_en_cycles", 32'(en_n), 2);
    chk("t1_we_cycles", 32'(we_n), 0);
    chk("t1_addr", 32'(a), 32'h005);
    chk("t1_stable", 32'(stable), 1);
    @(posedge clk); #1;
    m0_req = 0;
    chk("t1_idle_busy", 32'(busy), 0);
    chk("t1_idle_ack", 32'(m0_ack), 0);
    chk("t1_idle_rdata", 32'(m0_rdata), 0);

    // 2: m1 write 0x3FF <= 0x1234
    m1_req = 1; m1_we = 1; m1_addr = 10'h3FF; m1_wdata = 16'h1234;
    wait_ack(who, rd, lat, en_n, we_n, a, wd, stable);
    chk("t2_who", 32'(who), 1);
    chk("t2_rdata", 32'(rd), 0);
    chk("t2_lat", 32'(lat), 3);
    chk("t2_en_cycles", 32'(en_n), 1);
    chk("t2_we_cycles", 32'(we_n), 1);
    chk("t2_addr", 32'(a), 32'h3FF);
    chk("t2_wdata", 32'(wd), 32'h1234);
    chk("t2_mem", 32'(mem[10'h3FF]), 32'h1234);
    @(posedge clk); #1;
    m1_req = 0;
    chk("t2_owner_hold", 32'(owner), 1);
    chk("t2_idle_busy", 32'(busy), 0);

    // 3: both requesting, MAX_STREAK=4 -> m0 x4, m1, m0
    m0_req = 1; m0_we = 0; m0_addr = 10'h005;
    m1_req = 1; m1_we = 1; m1_addr = 10'h100; m1_wdata = 16'h5555;
    for (int k = 0; k < 6; k++) begin
      wait_ack(who, rd, lat, en_n, we_n, a, wd, stable);
      chk($sformatf("t3_order%0d", k), 32'(who), 32'(exp_order[k]));
      if (k == 4) chk("t3_streak_clr", 32'(u0.streak_q), 0);
      if (k == 5) chk("t3_streak_after", 32'(u0.streak_q), 1);
      @(posedge clk); #1;
    end
    m0_req = 0; m1_req = 0;
    chk("t3_mem", 32'(mem[10'h100]), 32'h5555);

    // 4: strict priority instance, 20 contended transactions
    u1_m0_req = 1; u1_m1_req = 1;
    n0 = 0; n1 = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (u1_m0_ack) n0++;
      if (u1_m1_ack) n1++;
      if (n0 + n1 == 20) break;
    end
    @(posedge clk); #1;
    u1_m0_req = 0; u1_m1_req = 0;
    chk("t4_m0_grants", 32'(n0), 20);
    chk("t4_m1_grants", 32'(n1), 0);
    chk("t4_streak_sat", 32'(u1.streak_q), 15);

    // 5: reset pulse in the second ACCESS cycle of an m0 read
    m0_req = 1; m0_we = 0; m0_addr = 10'h005;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0; m0_req = 0;
    #1;
    chk("t5_mem_en", 32'(mem_en), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_owner", 32'(owner), 0);
    chk("t5_mem_addr", 32'(mem_addr), 0);
    chk("t5_ack", 32'(m0_ack), 0);
    @(posedge clk); #2 rst = 1'b1;
    hits = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (m0_ack || mem_en) hits++;
    end
    chk("t5_no_ack", 32'(hits), 0);
    @(posedge clk); #1;
    m0_req = 1; m0_we = 0; m0_addr = 10'h005;
    wait_ack(who, rd, lat, en_n, we_n, a, wd, stable);
    chk("t5_next_who", 32'(who), 0);
    chk("t5_next_rdata", 32'(rd), 32'hBEEF);
    chk("t5_next_lat", 32'(lat), 4);
    @(posedge clk); #1;
    m0_req = 0;

    // 6: m0 address changes mid-ACCESS; m1 requests during ACK
    m0_req = 1; m0_we = 0; m0_addr = 10'h010;
    @(posedge clk); #1;
    m0_addr = 10'h020;
    wait_ack(who, rd, lat, en_n, we_n, a, wd, stable);
    chk("t6_who", 32'(who), 0);
    chk("t6_addr", 32'(a), 32'h010);
    chk("t6_stable", 32'(stable), 1);
    chk("t6_rdata", 32'(rd), 32'hA010);
    m1_req = 1; m1_we = 1; m1_addr = 10'h200; m1_wdata = 16'h7777;
    @(posedge clk); #1;
    m0_req = 0;
    wait_ack(who, rd, lat, en_n, we_n, a, wd, stable);
    chk("t6_m1_who", 32'(who), 1);
    chk("t6_m1_lat", 32'(lat), 3);
    chk("t6_m1_addr", 32'(a), 32'h200);
    @(posedge clk); #1;
    m1_req = 0;
    chk("t6_mem", 32'(mem[10'h200]), 32'h7777);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
